// File: rtl/regfile_pkg.sv
// Shared defaults and address types for the 2R/1W register file with busy scoreboard.
package regfile_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT = 5;
  localparam int unsigned DEPTH      = 1 << AW_DEFAULT;

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file: read ports, writeback port, issue port.
interface regfile_scoreboard_if #(
  parameter int unsigned DW = regfile_pkg::DW_DEFAULT,
  parameter int unsigned AW = regfile_pkg::AW_DEFAULT
);
  logic [AW-1:0] rna;
  logic [AW-1:0] rnb;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic          busy_a;
  logic          busy_b;
  logic          we;
  logic [AW-1:0] wn;
  logic [DW-1:0] d;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          busy_any;

  modport master (
    output rna, rnb, we, wn, d, iss_valid, iss_rd,
    input  qa, qb, busy_a, busy_b, busy_any
  );

  modport slave (
    input  rna, rnb, we, wn, d, iss_valid, iss_rd,
    output qa, qb, busy_a, busy_b, busy_any
  );

endinterface

// File: rtl/rf_busy_table.sv
// Per-register pending-write scoreboard: issue sets, writeback clears, set wins on a tie.
module rf_busy_table
  import regfile_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] idx_a,
  input  logic [AW-1:0] idx_b,
  output logic          busy_a,
  output logic          busy_b,
  output logic          busy_any
);

  localparam int unsigned NumRegs = 1 << AW;

  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    // Applied last so a new producer overrides the retiring one.
    if (set_en) busy_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clrn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_a   = busy_q[idx_a];
  assign busy_b   = busy_q[idx_b];
  assign busy_any = |busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with optional write-through bypass and busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned AW      = AW_DEFAULT,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input logic                 clk,
  input logic                 clrn,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned NumRegs = 1 << AW;

  logic [DW-1:0] regs_q [NumRegs];
  logic          wr_en;
  logic          iss_en;
  logic          tbl_busy_a;
  logic          tbl_busy_b;
  logic          tbl_busy_any;
  logic          fwd_a;
  logic          fwd_b;

  assign wr_en  = bus.we && !(ZERO_R0 && (bus.wn == AW'(REG_ZERO)));
  assign iss_en = bus.iss_valid && !(ZERO_R0 && (bus.iss_rd == AW'(REG_ZERO)));

  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.wn] <= bus.d;
    end
  end

  rf_busy_table #(
    .AW(AW)
  ) u_busy (
    .clk     (clk),
    .clrn    (clrn),
    .set_en  (iss_en),
    .set_idx (bus.iss_rd),
    .clr_en  (wr_en),
    .clr_idx (bus.wn),
    .idx_a   (bus.rna),
    .idx_b   (bus.rnb),
    .busy_a  (tbl_busy_a),
    .busy_b  (tbl_busy_b),
    .busy_any(tbl_busy_any)
  );

  // No forwarding during reset, and none when the same cycle re-issues the read register.
  assign fwd_a = BYPASS && clrn && wr_en && (bus.wn == bus.rna) &&
                 !(bus.iss_valid && (bus.iss_rd == bus.rna));
  assign fwd_b = BYPASS && clrn && wr_en && (bus.wn == bus.rnb) &&
                 !(bus.iss_valid && (bus.iss_rd == bus.rnb));

  always_comb begin
    bus.qa     = (ZERO_R0 && (bus.rna == AW'(REG_ZERO))) ? '0 : regs_q[bus.rna];
    bus.qb     = (ZERO_R0 && (bus.rnb == AW'(REG_ZERO))) ? '0 : regs_q[bus.rnb];
    bus.busy_a = tbl_busy_a;
    bus.busy_b = tbl_busy_b;
    if (fwd_a) begin
      bus.qa     = bus.d;
      bus.busy_a = 1'b0;
    end
    if (fwd_b) begin
      bus.qb     = bus.d;
      bus.busy_b = 1'b0;
    end
  end

  assign bus.busy_any = tbl_busy_any;

endmodule
